// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard tracker for the in-order pipeline. Every instruction that leaves
//   ID is recorded in a STAGES-deep in-flight tracker (0 = EX, 1 = MEM, ...).
//   For each source operand of the instruction in ID the unit chooses one of
//   three outcomes: read the register file, forward from a younger stage, or
//   stall. It also handles a global freeze (hold), a branch flush, and keeps
//   a saturating count of stall cycles.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   id_valid               ID holds a real instruction
//   id_rs1/id_rs2(_en)     source registers and their read enables
//   id_rd, id_we, id_load  destination, write enable, load flag of ID instr
//   hold                   freeze: tracker and stall_cnt keep their values
//   flush                  ID instruction is wrong-path; dropped, never stalls
//   stage_data             result of stage i on [i*XLEN +: XLEN]
//   fwd_a/b_sel            0 = register file, i+1 = stage i
//   fwd_a/b_data           forwarded value, 0 when sel = 0
//   stall_id               hold IF/ID and insert a bubble into EX
//   stall_cnt              saturating count of stall cycles

// Per-operand resolver: finds the youngest matching writer and decides
// forward / stall / register file for one source operand.
module pipe_hazard_opnd #(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int STAGES   = 3,
   parameter int LOAD_RDY = 1,
   parameter int SEL_W    = $clog2(STAGES + 1)
) (
   input  logic                             en,
   input  logic [REG_AW-1:0]                rs,
   input  logic [STAGES-1:0]                ent_wr,
   input  logic [STAGES-1:0][REG_AW-1:0]    ent_rd,
   input  logic [STAGES-1:0]                ent_load,
   input  logic [STAGES-1:0][XLEN-1:0]      sd,
   output logic [SEL_W-1:0]                 sel,
   output logic [XLEN-1:0]                  data,
   output logic                             stall_req
);

   logic found;

   always_comb begin
      sel       = '0;
      data      = '0;
      stall_req = 1'b0;
      found     = 1'b0;
      // Scan from youngest (EX) outward; the first hit shadows older ones.
      for (int i = 0; i < STAGES; i++) begin
         if (!found && en && (rs != '0) && ent_wr[i] && (ent_rd[i] == rs)) begin
            found = 1'b1;
            if (!ent_load[i] || (i >= LOAD_RDY)) begin
               sel  = SEL_W'(i + 1);
               data = sd[i];
            end else begin
               stall_req = 1'b1;
            end
         end
      end
   end

endmodule

module pipe_hazard_unit #(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int STAGES   = 3,
   parameter int LOAD_RDY = 1,
   parameter int SEL_W    = $clog2(STAGES + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [REG_AW-1:0]        id_rs1,
   input  logic [REG_AW-1:0]        id_rs2,
   input  logic                     id_rs1_en,
   input  logic                     id_rs2_en,
   input  logic [REG_AW-1:0]        id_rd,
   input  logic                     id_we,
   input  logic                     id_load,
   input  logic                     hold,
   input  logic                     flush,
   input  logic [STAGES*XLEN-1:0]   stage_data,
   output logic [SEL_W-1:0]         fwd_a_sel,
   output logic [SEL_W-1:0]         fwd_b_sel,
   output logic [XLEN-1:0]          fwd_a_data,
   output logic [XLEN-1:0]          fwd_b_data,
   output logic                     stall_id,
   output logic [31:0]              stall_cnt
);

   // Tracker state; only the valid bits need reset.
   logic [STAGES-1:0]               vld_pipe;
   logic [STAGES-1:0][REG_AW-1:0]   ent_rd;
   logic [STAGES-1:0]               ent_we;
   logic [STAGES-1:0]               ent_load;
   logic [STAGES-1:0]               ent_wr;

   logic [STAGES-1:0][XLEN-1:0]     sd;
   logic [1:0][REG_AW-1:0]          op_rs;
   logic [1:0]                      op_en;
   logic [1:0][SEL_W-1:0]           op_sel;
   logic [1:0][XLEN-1:0]            op_data;
   logic [1:0]                      op_stall;
   logic                            id_push;

   assign sd = stage_data;

   // An entry writing x0 never counts as a producer.
   always_comb begin
      for (int i = 0; i < STAGES; i++)
         ent_wr[i] = vld_pipe[i] & ent_we[i] & (ent_rd[i] != '0);
   end

   assign op_rs = {id_rs2, id_rs1};
   assign op_en = {id_rs2_en & id_valid, id_rs1_en & id_valid};

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_opnd
         pipe_hazard_opnd #(
            .XLEN(XLEN), .REG_AW(REG_AW), .STAGES(STAGES),
            .LOAD_RDY(LOAD_RDY), .SEL_W(SEL_W)
         ) u_opnd (
            .en       (op_en[g]),
            .rs       (op_rs[g]),
            .ent_wr   (ent_wr),
            .ent_rd   (ent_rd),
            .ent_load (ent_load),
            .sd       (sd),
            .sel      (op_sel[g]),
            .data     (op_data[g]),
            .stall_req(op_stall[g])
         );
      end
   endgenerate

   assign fwd_a_sel  = op_sel[0];
   assign fwd_b_sel  = op_sel[1];
   assign fwd_a_data = op_data[0];
   assign fwd_b_data = op_data[1];

   // Flush beats stall (wrong-path instr is dropped anyway); hold freezes
   // everything, so a stall only takes effect on the cycle hold drops.
   assign stall_id = (|op_stall) & ~flush & ~hold;
   assign id_push  = id_valid & ~flush & ~stall_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe  <= '0;
         stall_cnt <= '0;
      end else if (!hold) begin
         for (int i = STAGES - 1; i > 0; i--) begin
            vld_pipe[i] <= vld_pipe[i-1];
            ent_rd[i]   <= ent_rd[i-1];
            ent_we[i]   <= ent_we[i-1];
            ent_load[i] <= ent_load[i-1];
         end
         vld_pipe[0] <= id_push;
         ent_rd[0]   <= id_rd;
         ent_we[0]   <= id_we;
         ent_load[0] <= id_load;
         if (stall_id && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

   localparam int XLEN = 32, REG_AW = 5, STAGES = 3, SEL_W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic id_valid = 0, id_rs1_en = 0, id_rs2_en = 0, id_we = 0, id_load = 0;
   logic hold = 0, flush = 0;
   logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic [STAGES*XLEN-1:0] stage_data = '0;
   logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
   logic [XLEN-1:0] fwd_a_data, fwd_b_data;
   logic stall_id;
   logic [31:0] stall_cnt;

   always #5 clk = ~clk;

   pipe_hazard_unit dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
      .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
      .hold(hold), .flush(flush), .stage_data(stage_data),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
      .stall_id(stall_id), .stall_cnt(stall_cnt)
   );

   typedef struct {
      string       nm;
      bit          chkf;   // compare fwd outputs too
      logic [31:0] sa, da, sb, db, st, cnt;
   } exp_t;

   exp_t sb_q[$];
   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: outputs are combinational, so compare mid-cycle for each
   // vector the stimulus queued during this cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.nm, "stall_id", {31'd0, stall_id}, e.st);
         chk(e.nm, "stall_cnt", stall_cnt, e.cnt);
         if (e.chkf) begin
            chk(e.nm, "fwd_a_sel", {30'd0, fwd_a_sel}, e.sa);
            chk(e.nm, "fwd_a_data", fwd_a_data, e.da);
            chk(e.nm, "fwd_b_sel", {30'd0, fwd_b_sel}, e.sb);
            chk(e.nm, "fwd_b_data", fwd_b_data, e.db);
         end
      end
   end

   // Drive one ID cycle, queue its expectation, advance to the next cycle.
   task automatic vec(
      input string nm,
      input logic v, input logic [4:0] r1, input logic e1, input logic [4:0] r2, input logic e2,
      input logic [4:0] rd, input logic we, input logic ld, input logic hd, input logic fl,
      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
      input bit cf, input logic [31:0] sa, input logic [31:0] da,
      input logic [31:0] sb, input logic [31:0] db, input logic [31:0] st, input logic [31:0] cnt);
      exp_t e;
      id_valid = v; id_rs1 = r1; id_rs1_en = e1; id_rs2 = r2; id_rs2_en = e2;
      id_rd = rd; id_we = we; id_load = ld; hold = hd; flush = fl;
      stage_data = {d2, d1, d0};
      e.nm = nm; e.chkf = cf; e.sa = sa; e.da = da; e.sb = sb; e.db = db; e.st = st; e.cnt = cnt;
      sb_q.push_back(e);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      //  name        v  rs1 e1 rs2 e2 rd we ld hd fl  sd0      sd1      sd2     cf sa da       sb db      st cnt
      vec("reset",    1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 32'h99,  32'h98,  32'h97,  1, 0, 0,       0, 0,       0, 0);
      vec("add_x5",   1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,       0,       0,       1, 0, 0,       0, 0,       0, 0);
      vec("alu_fwd",  1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1234,0,       0,       1, 1, 32'h1234,0, 0,       0, 0);
      vec("mem_fwd",  1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,       32'h55,  0,       1, 2, 32'h55,  0, 0,       0, 0);
      vec("wb_fwd",   1, 5, 1, 0, 0, 7, 1, 1, 0, 0, 0,       0,       32'h77,  1, 3, 32'h77,  0, 0,       0, 0);
      vec("ld_use",   1, 0, 0, 7, 1, 9, 1, 0, 0, 0, 0,       0,       0,       0, 0, 0,       0, 0,       1, 0);
      vec("ld_fwd",   1, 0, 0, 7, 1, 9, 1, 0, 0, 0, 0,       32'hCAFE,0,       1, 0, 0,       2, 32'hCAFE,0, 1);
      vec("wr_x3a",   1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,       0,       0,       1, 0, 0,       0, 0,       0, 1);
      vec("wr_x8",    1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0,       0,       0,       1, 0, 0,       0, 0,       0, 1);
      vec("wr_x3b",   1, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0,       32'h31,  0,       1, 2, 32'h31,  0, 0,       0, 1);
      vec("prio",     1, 3, 1, 0, 1, 0, 1, 0, 0, 0, 32'hA,   0,       32'hB,   1, 1, 32'hA,   0, 0,       0, 1);
      vec("x0",       1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 32'h10,  32'h33,  32'h12,  1, 0, 0,       2, 32'h33,  0, 1);
      vec("en_off",   0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 32'h1,   32'h2,   32'h3,   1, 0, 0,       0, 0,       0, 1);
      vec("ld_x7",    1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,       0,       0,       1, 0, 0,       0, 0,       0, 1);
      vec("hold1",    1, 7, 1, 0, 0,10, 1, 0, 1, 0, 0,       0,       0,       0, 0, 0,       0, 0,       0, 1);
      vec("hold2",    1, 7, 1, 0, 0,10, 1, 0, 1, 0, 0,       0,       0,       0, 0, 0,       0, 0,       0, 1);
      vec("hold3",    1, 7, 1, 0, 0,10, 1, 0, 1, 0, 0,       0,       0,       0, 0, 0,       0, 0,       0, 1);
      vec("unhold",   1, 7, 1, 0, 0,10, 1, 0, 0, 0, 0,       0,       0,       0, 0, 0,       0, 0,       1, 1);
      vec("hold_fwd", 1, 7, 1, 0, 0,10, 1, 0, 0, 0, 0,       32'hBEEF,0,       1, 2, 32'hBEEF,0, 0,       0, 2);
      vec("ld_x12",   1, 0, 0, 0, 0,12, 1, 1, 0, 0, 0,       0,       0,       1, 0, 0,       0, 0,       0, 2);
      vec("flush",    1,12, 1, 0, 0,13, 1, 0, 0, 1, 0,       0,       0,       0, 0, 0,       0, 0,       0, 2);
      vec("post_fl",  1,13, 1,12, 1, 0, 0, 0, 0, 0, 32'h1,   32'h4444,32'h5,   1, 0, 0,       2, 32'h4444,0, 2);
      vec("ld_x14",   1, 0, 0, 0, 0,14, 1, 1, 0, 0, 0,       0,       0,       1, 0, 0,       0, 0,       0, 2);
      rst = 1'b1;
      vec("rst_stall",1,14, 1, 0, 0, 0, 0, 0, 0, 0, 0,       0,       0,       0, 0, 0,       0, 0,       1, 2);
      rst = 1'b0;
      vec("post_rst", 1,14, 1, 0, 0, 0, 0, 0, 0, 0, 32'h7,   32'h8,   32'h9,   1, 0, 0,       0, 0,       0, 0);
      id_valid = 1'b0;
      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
